// File: rtl/msx_sdram_pkg.sv
// Shared types and helpers for the MSX SDRAM command-port arbiter.
package msx_sdram_pkg;

  localparam int CPU_ADDR_W  = 23;
  localparam int WORD_ADDR_W = 21;

  typedef enum logic [1:0] {
    OWNER_NONE    = 2'd0,
    OWNER_CPU     = 2'd1,
    OWNER_VDP     = 2'd2,
    OWNER_REFRESH = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_e;

  // DQM for a single-byte write: every lane masked except the addressed one.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return ~(4'b0001 << lane);
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/msx_sdram_refresh_timer.sv
// Auto-refresh interval counter with a saturating count of owed refreshes.
module msx_sdram_refresh_timer #(
  parameter int INTERVAL = 660,
  parameter int URGENT   = 3,
  parameter int PW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done,
  output logic [PW-1:0] pending
);
  localparam int CW = $clog2(INTERVAL + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          tick;

  assign tick    = (cnt_q == CW'(INTERVAL - 1));
  assign pending = pending_q;

  // Interval wrap and pending bookkeeping; a coincident tick and done cancel out
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (tick) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (tick && !done) begin
      if (pending_q < PW'(URGENT)) begin
        pending_d = pending_q + PW'(1);
      end else begin
        pending_d = pending_q;
      end
    end else if (!tick && done && (pending_q != {PW{1'b0}})) begin
      pending_d = pending_q - PW'(1);
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= {CW{1'b0}};
      pending_q <= {PW{1'b0}};
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/msx_sdram_arbiter.sv
// Fixed-priority SDRAM command-port arbiter for CPU, video fetch and auto-refresh.
module msx_sdram_arbiter
  import msx_sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 660,
  parameter int REFRESH_URGENT   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  input  logic [CPU_ADDR_W-1:0]  cpu_address,
  input  logic [7:0]             cpu_wdata,
  output logic                   cpu_ack,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_rdata_en,
  input  logic                   vdp_req,
  input  logic [WORD_ADDR_W-1:0] vdp_address,
  output logic                   vdp_ack,
  output logic [31:0]            vdp_rdata,
  output logic                   vdp_rdata_en,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic                   mem_wr,
  output logic                   mem_refresh,
  output logic [WORD_ADDR_W-1:0] mem_address,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wdata_mask,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_rdata_en
);
  localparam int PW = $clog2(REFRESH_URGENT + 1);

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic [1:0]             lane_q, lane_d;
  logic                   mem_req_q, mem_req_d, mem_wr_q, mem_wr_d, mem_refresh_q, mem_refresh_d;
  logic [WORD_ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d, vdp_rdata_q, vdp_rdata_d;
  logic [3:0]             mem_mask_q, mem_mask_d;
  logic                   cpu_ack_q, cpu_ack_d, vdp_ack_q, vdp_ack_d;
  logic                   cpu_rdata_en_q, cpu_rdata_en_d, vdp_rdata_en_q, vdp_rdata_en_d;
  logic [7:0]             cpu_rdata_q, cpu_rdata_d;
  logic [PW-1:0]          pending;
  logic                   refresh_done, take_refresh;

  msx_sdram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL),
    .URGENT   (REFRESH_URGENT),
    .PW       (PW)
  ) u_refresh_timer (
    .clk     (clk),
    .reset   (reset),
    .done    (refresh_done),
    .pending (pending)
  );

  // Urgent refresh beats everyone; an ordinary owed refresh only fills idle slots
  assign take_refresh = (pending >= PW'(REFRESH_URGENT)) ||
                        (!vdp_req && !cpu_req && (pending != {PW{1'b0}}));

  // Arbitration, command sequencing and byte-lane steering
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    lane_d         = lane_q;
    mem_req_d      = mem_req_q;
    mem_wr_d       = mem_wr_q;
    mem_refresh_d  = mem_refresh_q;
    mem_address_d  = mem_address_q;
    mem_wdata_d    = mem_wdata_q;
    mem_mask_d     = mem_mask_q;
    cpu_ack_d      = 1'b0;
    vdp_ack_d      = 1'b0;
    cpu_rdata_en_d = 1'b0;
    vdp_rdata_en_d = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    vdp_rdata_d    = vdp_rdata_q;
    refresh_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_refresh) begin
          state_d       = ST_ISSUE;
          owner_d       = OWNER_REFRESH;
          mem_req_d     = 1'b1;
          mem_wr_d      = 1'b0;
          mem_refresh_d = 1'b1;
          mem_address_d = {WORD_ADDR_W{1'b0}};
          mem_wdata_d   = 32'h0000_0000;
          mem_mask_d    = 4'b0000;
        end else if (vdp_req) begin
          state_d       = ST_ISSUE;
          owner_d       = OWNER_VDP;
          vdp_ack_d     = 1'b1;
          mem_req_d     = 1'b1;
          mem_wr_d      = 1'b0;
          mem_refresh_d = 1'b0;
          mem_address_d = vdp_address;
          mem_wdata_d   = 32'h0000_0000;
          mem_mask_d    = 4'b0000;
        end else if (cpu_req) begin
          state_d       = ST_ISSUE;
          owner_d       = OWNER_CPU;
          cpu_ack_d     = 1'b1;
          lane_d        = cpu_address[1:0];
          mem_req_d     = 1'b1;
          mem_wr_d      = cpu_wr;
          mem_refresh_d = 1'b0;
          mem_address_d = cpu_address[CPU_ADDR_W-1:2];
          mem_wdata_d   = {4{cpu_wdata}};
          mem_mask_d    = cpu_wr ? lane_mask(cpu_address[1:0]) : 4'b0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          mem_req_d     = 1'b0;
          mem_wr_d      = 1'b0;
          mem_refresh_d = 1'b0;
          refresh_done  = (owner_q == OWNER_REFRESH);
          if (mem_wr_q || mem_refresh_q) begin
            state_d = ST_IDLE;
            owner_d = OWNER_NONE;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_DATA: begin
        if (mem_rdata_en) begin
          state_d = ST_IDLE;
          owner_d = OWNER_NONE;
          if (owner_q == OWNER_CPU) begin
            cpu_rdata_en_d = 1'b1;
            cpu_rdata_d    = lane_byte(mem_rdata, lane_q);
          end else if (owner_q == OWNER_VDP) begin
            vdp_rdata_en_d = 1'b1;
            vdp_rdata_d    = mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else begin
          state_d = ST_WAIT_DATA;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWNER_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWNER_NONE;
      lane_q         <= 2'b00;
      mem_req_q      <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_refresh_q  <= 1'b0;
      mem_address_q  <= {WORD_ADDR_W{1'b0}};
      mem_wdata_q    <= 32'h0000_0000;
      mem_mask_q     <= 4'b0000;
      cpu_ack_q      <= 1'b0;
      vdp_ack_q      <= 1'b0;
      cpu_rdata_en_q <= 1'b0;
      vdp_rdata_en_q <= 1'b0;
      cpu_rdata_q    <= 8'h00;
      vdp_rdata_q    <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      lane_q         <= lane_d;
      mem_req_q      <= mem_req_d;
      mem_wr_q       <= mem_wr_d;
      mem_refresh_q  <= mem_refresh_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_mask_q     <= mem_mask_d;
      cpu_ack_q      <= cpu_ack_d;
      vdp_ack_q      <= vdp_ack_d;
      cpu_rdata_en_q <= cpu_rdata_en_d;
      vdp_rdata_en_q <= vdp_rdata_en_d;
      cpu_rdata_q    <= cpu_rdata_d;
      vdp_rdata_q    <= vdp_rdata_d;
    end
  end

  assign cpu_ack        = cpu_ack_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign cpu_rdata_en   = cpu_rdata_en_q;
  assign vdp_ack        = vdp_ack_q;
  assign vdp_rdata      = vdp_rdata_q;
  assign vdp_rdata_en   = vdp_rdata_en_q;
  assign mem_req        = mem_req_q;
  assign mem_wr         = mem_wr_q;
  assign mem_refresh    = mem_refresh_q;
  assign mem_address    = mem_address_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wdata_mask = mem_mask_q;

endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// Directed bench for msx_sdram_arbiter with a short refresh interval.
module tb_msx_sdram_arbiter;
  import msx_sdram_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [22:0] cpu_address = 23'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_ack, cpu_rdata_en;
  logic [7:0]  cpu_rdata;
  logic        vdp_req = 1'b0;
  logic [20:0] vdp_address = 21'h0;
  logic        vdp_ack, vdp_rdata_en;
  logic [31:0] vdp_rdata;
  logic        mem_req, mem_wr, mem_refresh;
  logic        mem_ack = 1'b0, mem_rdata_en = 1'b0;
  logic [20:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wdata_mask;
  logic [31:0] mem_rdata = 32'h0;
  logic [103:0] outs;

  int tests = 0;
  int failed = 0;

  msx_sdram_arbiter #(.REFRESH_INTERVAL(8), .REFRESH_URGENT(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rdata_en(cpu_rdata_en),
    .vdp_req(vdp_req), .vdp_address(vdp_address), .vdp_ack(vdp_ack),
    .vdp_rdata(vdp_rdata), .vdp_rdata_en(vdp_rdata_en),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wdata_mask(mem_wdata_mask),
    .mem_rdata(mem_rdata), .mem_rdata_en(mem_rdata_en)
  );

  assign outs = {cpu_ack, cpu_rdata, cpu_rdata_en, vdp_ack, vdp_rdata, vdp_rdata_en,
                 mem_req, mem_wr, mem_refresh, mem_address, mem_wdata, mem_wdata_mask};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; vdp_req = 1'b0;
    mem_ack = 1'b0; mem_rdata_en = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_outs", 128'(outs), 128'(0));
    chk("reset_state", 128'(dut.state_q), 128'(ST_IDLE));
    chk("reset_pending", 128'(dut.pending), 128'(0));

    // CPU byte write to lane 1
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_address = 23'h000005; cpu_wdata = 8'hA5;
    cyc();
    chk("wr_cpu_ack", 128'(cpu_ack), 128'(1));
    chk("wr_mem_req", 128'(mem_req), 128'(1));
    chk("wr_mem_wr", 128'(mem_wr), 128'(1));
    chk("wr_addr", 128'(mem_address), 128'(21'h000001));
    chk("wr_wdata", 128'(mem_wdata), 128'(32'hA5A5A5A5));
    chk("wr_mask", 128'(mem_wdata_mask), 128'(4'b1101));
    cyc();
    cpu_req = 1'b0;
    chk("wr_ack_pulse", 128'(cpu_ack), 128'(0));
    chk("wr_req_held", 128'(mem_req), 128'(1));
    chk("wr_addr_held", 128'(mem_address), 128'(21'h000001));
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("wr_req_drop", 128'(mem_req), 128'(0));
    chk("wr_idle", 128'(dut.state_q), 128'(ST_IDLE));

    // CPU byte read from lane 3
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_address = 23'h000007;
    cyc();
    cpu_req = 1'b0;
    chk("rd_cpu_ack", 128'(cpu_ack), 128'(1));
    chk("rd_mem_wr", 128'(mem_wr), 128'(0));
    chk("rd_mask", 128'(mem_wdata_mask), 128'(4'b0000));
    chk("rd_addr", 128'(mem_address), 128'(21'h000001));
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("rd_wait", 128'(dut.state_q), 128'(ST_WAIT_DATA));
    chk("rd_no_en_yet", 128'(cpu_rdata_en), 128'(0));
    mem_rdata = 32'h11223344; mem_rdata_en = 1'b1;
    cyc();
    mem_rdata_en = 1'b0;
    chk("rd_en", 128'(cpu_rdata_en), 128'(1));
    chk("rd_byte", 128'(cpu_rdata), 128'(8'h11));
    chk("rd_vdp_quiet", 128'(vdp_rdata_en), 128'(0));
    cyc();
    chk("rd_en_pulse", 128'(cpu_rdata_en), 128'(0));

    // Simultaneous requests: video first, CPU after video returns to IDLE
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_address = 23'h000000; cpu_wdata = 8'h3C;
    vdp_req = 1'b1; vdp_address = 21'h012345;
    cyc();
    chk("pri_vdp_ack", 128'(vdp_ack), 128'(1));
    chk("pri_cpu_wait", 128'(cpu_ack), 128'(0));
    chk("pri_vdp_addr", 128'(mem_address), 128'(21'h012345));
    vdp_req = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    mem_rdata = 32'hDEADBEEF; mem_rdata_en = 1'b1;
    cyc();
    mem_rdata_en = 1'b0;
    chk("pri_vdp_en", 128'(vdp_rdata_en), 128'(1));
    chk("pri_vdp_data", 128'(vdp_rdata), 128'(32'hDEADBEEF));
    chk("pri_cpu_not_yet", 128'(cpu_ack), 128'(0));
    cyc();
    chk("pri_cpu_ack", 128'(cpu_ack), 128'(1));
    chk("pri_cpu_mask", 128'(mem_wdata_mask), 128'(4'b1110));
    chk("pri_cpu_wdata", 128'(mem_wdata), 128'(32'h3C3C3C3C));
    cpu_req = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;

    // Refresh urgency: stall a CPU write 30 cycles so pending saturates
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_address = 23'h000004; cpu_wdata = 8'h00;
    cyc();
    vdp_req = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    chk("urg_pending_sat", 128'(dut.pending), 128'(3));
    chk("urg_still_issue", 128'(mem_req), 128'(1));
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    cyc();
    chk("urg_refresh", 128'(mem_refresh), 128'(1));
    chk("urg_req", 128'(mem_req), 128'(1));
    chk("urg_mem_wr", 128'(mem_wr), 128'(0));
    chk("urg_no_acks", 128'({vdp_ack, cpu_ack}), 128'(2'b00));
    chk("urg_mask", 128'(mem_wdata_mask), 128'(4'b0000));
    cpu_req = 1'b0; vdp_req = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("dec_pending", 128'(dut.pending), 128'(2));

    // Idle refresh, acked on the same cycle as a tick: pending stays 2
    cyc();
    chk("idle_refresh", 128'(mem_refresh), 128'(1));
    for (int i = 0; i < 4; i++) cyc();
    chk("coin_pre", 128'(dut.pending), 128'(2));
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("coin_pending", 128'(dut.pending), 128'(2));
    chk("coin_idle", 128'(dut.state_q), 128'(ST_IDLE));

    // Reset during WAIT_DATA, then a stray rdata pulse
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_address = 23'h000002;
    cyc();
    cpu_req = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("abort_in_wait", 128'(dut.state_q), 128'(ST_WAIT_DATA));
    reset = 1'b1;
    cyc();
    chk("abort_outs", 128'(outs), 128'(0));
    chk("abort_state", 128'(dut.state_q), 128'(ST_IDLE));
    reset = 1'b0;
    mem_rdata = 32'hFFFFFFFF; mem_rdata_en = 1'b1;
    cyc();
    mem_rdata_en = 1'b0;
    chk("abort_no_rdata_en", 128'({cpu_rdata_en, vdp_rdata_en}), 128'(2'b00));
    chk("abort_outs_after", 128'(outs), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
